// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
// Passive Wishbone bus tracer. Watches one master port and records
// {we, adr, dat} for every acknowledged cycle whose address lies inside
// [win_lo, win_hi] into a circular RAM. A host drains the entries oldest-first.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   mon_cyc/stb/ack/we      snooped Wishbone handshake and direction
//   mon_adr                 snooped address
//   mon_dat_w / mon_dat_r   snooped master write data / slave read data
//   win_lo, win_hi          inclusive capture address window (unsigned)
//   wrap_mode               1: overwrite oldest when full, 0: stop when full
//   arm                     pulse: clear buffer and start capturing
//   halt                    pulse: stop capturing, keep contents
//   rd_en                   pulse: pop oldest entry
//   rd_valid, rd_data       popped entry, valid for one cycle
//   count                   number of entries held
//   overflow                sticky: an entry was dropped or overwritten
//   running                 capture state is RUN
// -----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int adr_width  = 32,
    parameter int dat_width  = 32,
    parameter int depth_log2 = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mon_cyc,
    input  logic                           mon_stb,
    input  logic                           mon_ack,
    input  logic                           mon_we,
    input  logic [adr_width-1:0]           mon_adr,
    input  logic [dat_width-1:0]           mon_dat_w,
    input  logic [dat_width-1:0]           mon_dat_r,
    input  logic [adr_width-1:0]           win_lo,
    input  logic [adr_width-1:0]           win_hi,
    input  logic                           wrap_mode,
    input  logic                           arm,
    input  logic                           halt,
    input  logic                           rd_en,
    output logic                           rd_valid,
    output logic [adr_width+dat_width:0]   rd_data,
    output logic [depth_log2:0]            count,
    output logic                           overflow,
    output logic                           running
);

    localparam int ent_width = 1 + adr_width + dat_width;
    localparam int depth     = 2 ** depth_log2;

    // Pointer / counter helper constants (depth_log2 must be >= 2).
    localparam logic [depth_log2-1:0] ptr_zero   = {depth_log2{1'b0}};
    localparam logic [depth_log2-1:0] ptr_one    = {{(depth_log2-1){1'b0}}, 1'b1};
    localparam logic [depth_log2:0]   cnt_zero   = {(depth_log2+1){1'b0}};
    localparam logic [depth_log2:0]   cnt_one    = {{depth_log2{1'b0}}, 1'b1};
    localparam logic [depth_log2:0]   full_count = {1'b1, {depth_log2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [ent_width-1:0]    mem_r [0:depth-1];
    logic [depth_log2-1:0]   wr_ptr_r;
    logic [depth_log2-1:0]   rd_ptr_r;
    logic [depth_log2:0]     count_r;
    logic [depth_log2:0]     count_nxt_s;
    logic                    overflow_r;
    logic                    rd_valid_r;
    logic [ent_width-1:0]    rd_data_r;
    logic                    running_r;

    logic                    hit_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    cap_s;
    logic                    wr_s;
    logic                    drop_s;
    logic                    pop_s;
    logic                    inc_s;
    logic                    rd_adv_s;
    logic [dat_width-1:0]    cap_dat_s;
    logic [ent_width-1:0]    cap_ent_s;

    assign hit_s   = mon_cyc & mon_stb & mon_ack &
                     (mon_adr >= win_lo) & (mon_adr <= win_hi);
    assign full_s  = (count_r == full_count);
    assign empty_s = (count_r == cnt_zero);

    // arm clears the buffer on this edge, so neither a hit nor a pop in the
    // arm cycle may act on the old contents.
    assign cap_s   = hit_s & (state_r == ST_RUN) & ~arm;
    assign pop_s   = rd_en & ~empty_s & ~arm;
    assign wr_s    = cap_s & (~full_s | wrap_mode);
    assign drop_s  = cap_s & full_s & ~wrap_mode;

    // A wrap overwrite consumes the oldest slot; when a pop happens in the same
    // cycle the pop already advances rd_ptr, so the two advances merge into one.
    assign rd_adv_s = pop_s | (wr_s & full_s);
    // Full-wrap write with a pop behaves like a normal push: count stays put.
    assign inc_s    = wr_s & (~full_s | pop_s);

    assign cap_dat_s = mon_we ? mon_dat_w : mon_dat_r;
    assign cap_ent_s = {mon_we, mon_adr, cap_dat_s};

    // Next-state logic for the capture FSM; arm has priority over halt.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) state_nxt_s = ST_RUN;
                else     state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (arm)         state_nxt_s = ST_RUN;
                else if (halt)   state_nxt_s = ST_IDLE;
                else if (drop_s) state_nxt_s = ST_STOPPED;
                else             state_nxt_s = ST_RUN;
            end
            ST_STOPPED: begin
                if (arm)       state_nxt_s = ST_RUN;
                else if (halt) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_STOPPED;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Occupancy update from push/pop of this cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({inc_s, pop_s})
            2'b10:   count_nxt_s = count_r + cnt_one;
            2'b01:   count_nxt_s = count_r - cnt_one;
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM state register and registered running flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Trace RAM write port; contents are only ever read through a valid pop.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= cap_ent_s;
        end
    end

    // Pointers, occupancy, overflow flag and read-out register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= ptr_zero;
            rd_ptr_r   <= ptr_zero;
            count_r    <= cnt_zero;
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {ent_width{1'b0}};
        end else if (arm) begin
            wr_ptr_r   <= ptr_zero;
            rd_ptr_r   <= ptr_zero;
            count_r    <= cnt_zero;
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_s)     wr_ptr_r <= wr_ptr_r + ptr_one;
            if (rd_adv_s) rd_ptr_r <= rd_ptr_r + ptr_one;
            count_r <= count_nxt_s;
            // Any hit against a full buffer loses or overwrites an entry.
            if (cap_s & full_s) overflow_r <= 1'b1;
            rd_valid_r <= pop_s;
            // Read happens before this edge's overwrite, so the pop returns
            // the old entry even when wr_ptr == rd_ptr.
            if (pop_s) rd_data_r <= mem_r[rd_ptr_r];
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign running  = running_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buffer
// Directed self-checking bench for wb_trace_buffer (depth_log2 = 2, 4 entries).
// -----------------------------------------------------------------------------
module tb_wb_trace_buffer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DL = 2;

    logic              clk;
    logic              reset;
    logic              mon_cyc, mon_stb, mon_ack, mon_we;
    logic [AW-1:0]     mon_adr;
    logic [DW-1:0]     mon_dat_w, mon_dat_r;
    logic [AW-1:0]     win_lo, win_hi;
    logic              wrap_mode, arm, halt, rd_en;
    logic              rd_valid;
    logic [AW+DW:0]    rd_data;
    logic [DL:0]       count;
    logic              overflow, running;

    int n_checks = 0;
    int n_fails  = 0;

    wb_trace_buffer #(.adr_width(AW), .dat_width(DW), .depth_log2(DL)) dut (
        .clk(clk), .reset(reset),
        .mon_cyc(mon_cyc), .mon_stb(mon_stb), .mon_ack(mon_ack), .mon_we(mon_we),
        .mon_adr(mon_adr), .mon_dat_w(mon_dat_w), .mon_dat_r(mon_dat_r),
        .win_lo(win_lo), .win_hi(win_hi), .wrap_mode(wrap_mode),
        .arm(arm), .halt(halt), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .overflow(overflow), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW+DW:0] ent(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {we, a, d};
    endfunction

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mon_cyc = 1'b0; mon_stb = 1'b0; mon_ack = 1'b0; mon_we = 1'b0;
    endtask

    // One acknowledged cycle; the unused data bus carries a decoy value.
    task automatic bus_hit(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_ack = 1'b1; mon_we = we;
        mon_adr = a;
        mon_dat_w = we ? d : 32'hDEAD_BEEF;
        mon_dat_r = we ? 32'hBAAD_F00D : d;
        tick();
        bus_idle();
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [AW+DW:0] exp);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"}, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        mon_adr = 32'h0; mon_dat_w = 32'h0; mon_dat_r = 32'h0;
        win_lo = 32'h0; win_hi = 32'hFFFF_FFFF;
        wrap_mode = 1'b0; arm = 1'b0; halt = 1'b0; rd_en = 1'b0;
        tick(); tick();
        check("rst_count", count, 3'd0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 65'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_run", running, 1'b0);
        reset = 1'b0;
        tick();

        // Basic write capture and ordered drain.
        pulse_arm();
        check("arm_run", running, 1'b1);
        bus_hit(1'b1, 32'h100, 32'hA);
        bus_hit(1'b1, 32'h104, 32'hB);
        bus_hit(1'b1, 32'h108, 32'hC);
        check("t1_count", count, 3'd3);
        pop_expect("t1_p0", ent(1'b1, 32'h100, 32'hA));
        pop_expect("t1_p1", ent(1'b1, 32'h104, 32'hB));
        pop_expect("t1_p2", ent(1'b1, 32'h108, 32'hC));
        check("t1_empty", count, 3'd0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check("empty_pop_valid", rd_valid, 1'b0);
        check("empty_pop_count", count, 3'd0);

        // Address window boundaries, read data selection.
        win_lo = 32'h1000; win_hi = 32'h1FFF;
        pulse_arm();
        bus_hit(1'b0, 32'h0FFC, 32'h11);
        bus_hit(1'b0, 32'h1000, 32'h22);
        bus_hit(1'b0, 32'h1FFF, 32'h33);
        bus_hit(1'b0, 32'h2000, 32'h44);
        check("win_count", count, 3'd2);
        pop_expect("win_p0", ent(1'b0, 32'h1000, 32'h22));
        pop_expect("win_p1", ent(1'b0, 32'h1FFF, 32'h33));
        win_lo = 32'h0; win_hi = 32'hFFFF_FFFF;

        // Hits while IDLE are ignored.
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_run", running, 1'b0);
        bus_hit(1'b1, 32'h200, 32'h1);
        check("idle_count", count, 3'd0);
        check("idle_ovf", overflow, 1'b0);

        // Stop-when-full: fifth hit dropped.
        wrap_mode = 1'b0;
        pulse_arm();
        for (int i = 1; i <= 5; i++) bus_hit(1'b1, 32'h10 * i, i);
        check("stop_count", count, 3'd4);
        check("stop_run", running, 1'b0);
        check("stop_ovf", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) pop_expect("stop_pop", ent(1'b1, 32'h10 * i, i));
        pulse_arm();
        check("rearm_run", running, 1'b1);
        check("rearm_ovf", overflow, 1'b0);

        // Wrap mode: six hits keep the newest four. Hit in arm cycle not captured.
        wrap_mode = 1'b1;
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_ack = 1'b1; mon_we = 1'b1;
        mon_adr = 32'h999; mon_dat_w = 32'h9;
        pulse_arm();
        bus_idle();
        check("arm_hit_count", count, 3'd0);
        for (int i = 1; i <= 6; i++) bus_hit(1'b1, 32'h10 * i, i);
        check("wrap_count", count, 3'd4);
        check("wrap_ovf", overflow, 1'b1);
        check("wrap_run", running, 1'b1);
        for (int i = 3; i <= 6; i++) pop_expect("wrap_pop", ent(1'b1, 32'h10 * i, i));

        // Full wrap buffer: hit and pop in the same cycle.
        pulse_arm();
        for (int i = 1; i <= 4; i++) bus_hit(1'b1, 32'h10 * i, i);
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_ack = 1'b1; mon_we = 1'b1;
        mon_adr = 32'h50; mon_dat_w = 32'h5; rd_en = 1'b1;
        tick();
        bus_idle(); rd_en = 1'b0;
        check("both_valid", rd_valid, 1'b1);
        check("both_data", rd_data, ent(1'b1, 32'h10, 32'h1));
        check("both_count", count, 3'd4);
        for (int i = 2; i <= 5; i++) pop_expect("both_pop", ent(1'b1, 32'h10 * i, i));
        check("both_empty", count, 3'd0);

        // Async reset in the middle of a burst with a pop in flight.
        pulse_arm();
        mon_cyc = 1'b1; mon_stb = 1'b1; mon_ack = 1'b1; mon_we = 1'b1;
        mon_adr = 32'h300; mon_dat_w = 32'h7;
        tick(); tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check("pre_rst_valid", rd_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_valid", rd_valid, 1'b0);
        check("mid_rst_run", running, 1'b0);
        tick();
        bus_idle();
        reset = 1'b0;
        tick();
        check("post_rst_count", count, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
